// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch -- instruction fetch stage
//
// Holds the architectural fetch PC and fetches one word at a time from
// instruction memory over a req/gnt/rvalid handshake. The single-entry
// output buffer presents {pc, instr} to the IF/ID register through a
// valid/ready handshake. Redirects from EX reload the PC. A response that is
// still in flight for a stale PC is dropped when it arrives.
//
// Only one memory request is ever outstanding. With a zero-wait memory the
// sequence REQ -> WAIT -> HOLD gives one instruction every three cycles.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   redirect_i        one-cycle redirect pulse from EX
//   redirect_pc_i     redirect target (bits [1:0] forced to zero)
//   imem_req_o        request to instruction memory
//   imem_addr_o       word-aligned request address (always equals the PC)
//   imem_gnt_i        request accepted this cycle
//   imem_rvalid_i     response data valid
//   imem_rdata_i      response instruction word
//   if_valid_o        presented instruction is valid
//   if_ready_i        IF/ID accepts the presented instruction
//   if_pc_o           PC of the presented instruction
//   if_instr_o        presented instruction
//
// Optional build macro IFETCH_PERF_EN adds two free-running 32-bit counters:
//   perf_fetch_cnt_o  completed IF/ID handshakes
//   perf_kill_cnt_o   dropped responses plus buffers discarded by a redirect
// ---------------------------------------------------------------------------
module ifetch #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_0000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               if_valid_o,
  input  logic               if_ready_i,
  output logic [PC_W-1:0]    if_pc_o,
  output logic [INSTR_W-1:0] if_instr_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt_o,
  output logic [31:0]        perf_kill_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     req_pc_q, req_pc_d;
  logic                kill_q, kill_d;
  logic                req_q, req_d;
  logic                valid_q, valid_d;
  logic [PC_W-1:0]     out_pc_q, out_pc_d;
  logic [INSTR_W-1:0]  out_instr_q, out_instr_d;
  logic [PC_W-1:0]     redirect_tgt;

  // Masking rather than slicing keeps every redirect bit consumed while
  // forcing word alignment.
  assign redirect_tgt = redirect_pc_i & ~(PC_W'(3));

  // Next-state logic. A redirect always wins over the +4 update and over an
  // IF/ID acceptance; the kill flag remembers that the one in-flight
  // response belongs to a PC that is no longer on the architectural path.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    kill_d      = kill_q;
    valid_d     = valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;

    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (imem_gnt_i) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
        end
        if (redirect_i) begin
          pc_d = redirect_tgt;
          // The granted request was for the old PC.
          if (imem_gnt_i) begin
            kill_d = 1'b1;
          end
        end else if (imem_gnt_i) begin
          pc_d = pc_q + PC_W'(4);
        end
      end

      S_WAIT: begin
        if (redirect_i) begin
          pc_d = redirect_tgt;
          if (imem_rvalid_i) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            out_pc_d    = req_pc_q;
            out_instr_d = imem_rdata_i;
            valid_d     = 1'b1;
            state_d     = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect_i) begin
          pc_d    = redirect_tgt;
          valid_d = 1'b0;
          state_d = S_REQ;
        end else if (if_ready_i) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // The request strobe is registered from the next state so that it is
  // high exactly while the FSM sits in REQ.
  assign req_d = (state_d == S_REQ);

`ifdef IFETCH_PERF_EN
  logic fetch_evt;
  logic kill_evt;

  // A dropped response is either an rvalid arriving with the kill flag set
  // or one arriving in the same cycle as a redirect.
  assign fetch_evt = valid_q & if_ready_i & ~redirect_i;
  assign kill_evt  = ((state_q == S_WAIT) & imem_rvalid_i & (kill_q | redirect_i))
                   | ((state_q == S_HOLD) & redirect_i);
`else
  // No performance counters in this build.
`endif

  // State registers, with reset taking priority over every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      kill_q      <= 1'b0;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
`ifdef IFETCH_PERF_EN
      perf_fetch_cnt_o <= 32'd0;
      perf_kill_cnt_o  <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      kill_q      <= kill_d;
      req_q       <= req_d;
      valid_q     <= valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
`ifdef IFETCH_PERF_EN
      if (fetch_evt) begin
        perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      end
      if (kill_evt) begin
        perf_kill_cnt_o <= perf_kill_cnt_o + 32'd1;
      end
`endif
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;
  assign if_valid_o  = valid_q;
  assign if_pc_o     = out_pc_q;
  assign if_instr_o  = out_instr_q;

endmodule

// File: tb/tb_ifetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch -- self-checking bench for ifetch
//
// Phase 1 replays a cycle-accurate vector table through reset, basic fetch,
// stalls, grant withholding and the redirect corner cases. Phase 2 is a
// hand-written reset-priority / boot sequence. Phase 3 drives random memory
// timing, backpressure and redirects, and checks every delivered instruction
// against a program-order model: deliveries are consecutive words, restarting
// at the latest redirect target, and each carries the word stored at its PC.
// ---------------------------------------------------------------------------
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_kill_cnt_o;
`endif

  ifetch dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_ready_i    (if_ready_i),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_kill_cnt_o  (perf_kill_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
    logic [31:0] expInstr;
  } vec_t;

  vec_t vecs[$];
  int   nTests = 0;
  int   nFail  = 0;

  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic vec_t mkVec(
    input logic gnt, input logic rv, input logic [31:0] rd, input logic rdy,
    input logic redir, input logic [31:0] rpc,
    input logic req, input logic [31:0] addr, input logic v,
    input logic [31:0] pc, input logic [31:0] ins);
    vec_t r;
    r.gnt = gnt; r.rvalid = rv; r.rdata = rd; r.ready = rdy;
    r.redir = redir; r.rpc = rpc;
    r.expReq = req; r.expAddr = addr; r.expValid = v;
    r.expPc = pc; r.expInstr = ins;
    return r;
  endfunction

  task automatic applyStimulus(input logic gnt, input logic rv, input logic [31:0] rd,
                               input logic rdy, input logic redir, input logic [31:0] rpc);
    imem_gnt_i    = gnt;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    if_ready_i    = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] packOut(input logic req, input logic [31:0] addr,
                                           input logic v, input logic [31:0] pc,
                                           input logic [31:0] ins);
    return {30'd0, req, addr, v, pc, ins};
  endfunction

  // Random-phase state
  logic [31:0] expPc;
  int          nDeliv;
  int          sinceHs;
  logic        outstanding;
  logic        killPending;
  int          lat;
  logic [31:0] respAddr;
  logic        rGnt, rRv, rRdy, rRedir;
  logic [31:0] rRd, rRpc;
  logic        respNow;
  int unsigned expFetch;
  int unsigned expKill;

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

    // gnt, rv, rdata, ready, redir, rpc | req, addr, valid, pc, instr
    vecs.push_back(mkVec(0,0,0,1,0,0,                 0,32'h000,0,32'h000,32'd0));
    vecs.push_back(mkVec(1,0,0,1,0,0,                 1,32'h000,0,32'h000,32'd0));
    vecs.push_back(mkVec(0,1,instrOf(32'h0),1,0,0,    0,32'h004,0,32'h000,32'd0));
    vecs.push_back(mkVec(0,0,0,1,0,0,                 0,32'h004,1,32'h000,instrOf(32'h0)));
    vecs.push_back(mkVec(1,0,0,1,0,0,                 1,32'h004,0,32'h000,instrOf(32'h0)));
    vecs.push_back(mkVec(0,1,instrOf(32'h4),1,0,0,    0,32'h008,0,32'h000,instrOf(32'h0)));
    vecs.push_back(mkVec(0,0,0,1,0,0,                 0,32'h008,1,32'h004,instrOf(32'h4)));
    vecs.push_back(mkVec(1,0,0,1,0,0,                 1,32'h008,0,32'h004,instrOf(32'h4)));
    vecs.push_back(mkVec(0,1,instrOf(32'h8),0,0,0,    0,32'h00C,0,32'h004,instrOf(32'h4)));
    // HOLD with pc 0x8 stalled 5 cycles; stray gnt/rvalid must be ignored
    vecs.push_back(mkVec(0,0,0,0,0,0,                 0,32'h00C,1,32'h008,instrOf(32'h8)));
    vecs.push_back(mkVec(1,0,0,0,0,0,                 0,32'h00C,1,32'h008,instrOf(32'h8)));
    vecs.push_back(mkVec(0,1,BAD,0,0,0,               0,32'h00C,1,32'h008,instrOf(32'h8)));
    vecs.push_back(mkVec(0,0,0,0,0,0,                 0,32'h00C,1,32'h008,instrOf(32'h8)));
    vecs.push_back(mkVec(0,0,0,0,0,0,                 0,32'h00C,1,32'h008,instrOf(32'h8)));
    vecs.push_back(mkVec(0,0,0,1,0,0,                 0,32'h00C,1,32'h008,instrOf(32'h8)));
    // redirect to 0x203 together with the gnt for 0xC
    vecs.push_back(mkVec(1,0,0,1,1,32'h203,           1,32'h00C,0,32'h008,instrOf(32'h8)));
    vecs.push_back(mkVec(0,1,instrOf(32'hC),1,0,0,    0,32'h200,0,32'h008,instrOf(32'h8)));
    // gnt withheld 4 cycles at 0x200, with a stray rvalid in REQ
    vecs.push_back(mkVec(0,0,0,1,0,0,                 1,32'h200,0,32'h008,instrOf(32'h8)));
    vecs.push_back(mkVec(0,1,BAD,1,0,0,               1,32'h200,0,32'h008,instrOf(32'h8)));
    vecs.push_back(mkVec(0,0,0,1,0,0,                 1,32'h200,0,32'h008,instrOf(32'h8)));
    vecs.push_back(mkVec(0,0,0,1,0,0,                 1,32'h200,0,32'h008,instrOf(32'h8)));
    vecs.push_back(mkVec(1,0,0,1,0,0,                 1,32'h200,0,32'h008,instrOf(32'h8)));
    // redirect to 0x100 while waiting for 0x200's response
    vecs.push_back(mkVec(0,0,0,1,0,0,                 0,32'h204,0,32'h008,instrOf(32'h8)));
    vecs.push_back(mkVec(0,0,0,1,1,32'h100,           0,32'h204,0,32'h008,instrOf(32'h8)));
    vecs.push_back(mkVec(0,1,instrOf(32'h200),1,0,0,  0,32'h100,0,32'h008,instrOf(32'h8)));
    vecs.push_back(mkVec(1,0,0,1,0,0,                 1,32'h100,0,32'h008,instrOf(32'h8)));
    vecs.push_back(mkVec(0,1,instrOf(32'h100),1,0,0,  0,32'h104,0,32'h008,instrOf(32'h8)));
    // redirect to 0x40 in HOLD with ready high: no handshake
    vecs.push_back(mkVec(0,0,0,1,1,32'h040,           0,32'h104,1,32'h100,instrOf(32'h100)));
    vecs.push_back(mkVec(0,0,0,1,0,0,                 1,32'h040,0,32'h100,instrOf(32'h100)));
    vecs.push_back(mkVec(1,0,0,1,0,0,                 1,32'h040,0,32'h100,instrOf(32'h100)));
    // redirect to 0x80 in the same cycle as the response for 0x40
    vecs.push_back(mkVec(0,1,instrOf(32'h40),1,1,32'h080, 0,32'h044,0,32'h100,instrOf(32'h100)));
    vecs.push_back(mkVec(1,0,0,1,0,0,                 1,32'h080,0,32'h100,instrOf(32'h100)));
    vecs.push_back(mkVec(0,1,instrOf(32'h80),1,0,0,   0,32'h084,0,32'h100,instrOf(32'h100)));
    vecs.push_back(mkVec(0,0,0,1,0,0,                 0,32'h084,1,32'h080,instrOf(32'h80)));
    // redirect in REQ without gnt
    vecs.push_back(mkVec(0,0,0,1,1,32'h3FE,           1,32'h084,0,32'h080,instrOf(32'h80)));
    vecs.push_back(mkVec(0,0,0,1,0,0,                 1,32'h3FC,0,32'h080,instrOf(32'h80)));

    repeat (3) @(posedge clk);

    // Phase 1: vector table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      applyStimulus(vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata,
                    vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      checkOutput($sformatf("vec[%0d]", i),
                  packOut(imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o),
                  packOut(vecs[i].expReq, vecs[i].expAddr, vecs[i].expValid,
                          vecs[i].expPc, vecs[i].expInstr));
    end
    @(negedge clk);
`ifdef IFETCH_PERF_EN
    checkOutput("perf_fetch_vec", {96'd0, perf_fetch_cnt_o}, 128'd4);
    checkOutput("perf_kill_vec",  {96'd0, perf_kill_cnt_o},  128'd4);
`endif

    // Phase 2: reset beats a simultaneous gnt and redirect
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h500);
    @(negedge clk);
    checkOutput("reset_priority",
                packOut(imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o),
                packOut(1'b0, 32'h0, 1'b0, 32'h0, 32'h0));
`ifdef IFETCH_PERF_EN
    checkOutput("perf_reset", {64'd0, perf_fetch_cnt_o, perf_kill_cnt_o}, 128'd0);
`endif
    // BOOT ignores a stray rvalid and a redirect
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, BAD, 1'b1, 1'b1, 32'h500);
    @(negedge clk);
    checkOutput("boot_ignores",
                packOut(imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o),
                packOut(1'b1, 32'h0, 1'b0, 32'h0, 32'h0));

    // Phase 3: random memory timing, backpressure and redirects
    expPc       = 32'h0;
    nDeliv      = 0;
    sinceHs     = 0;
    outstanding = 1'b0;
    killPending = 1'b0;
    lat         = 0;
    respAddr    = 32'h0;
    expFetch    = 0;
    expKill     = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      respNow = outstanding && (lat == 0);
      rRv = 1'b0;
      rRd = $urandom;
      if (respNow) begin
        rRv = 1'b1;
        rRd = instrOf(respAddr);
      end else if (!outstanding && ($urandom_range(0, 7) == 0)) begin
        rRv = 1'b1;
      end
      rGnt   = ($urandom_range(0, 3) != 0);
      rRdy   = ($urandom_range(0, 3) != 0);
      rRedir = ($urandom_range(0, 15) == 0);
      rRpc   = $urandom;
      applyStimulus(rGnt, rRv, rRd, rRdy, rRedir, rRpc);

      if (if_valid_o && rRdy && !rRedir) begin
        checkOutput($sformatf("deliver[%0d]", nDeliv), {64'd0, if_pc_o, if_instr_o},
                    {64'd0, expPc, instrOf(expPc)});
        expPc = expPc + 32'd4;
        nDeliv++;
        expFetch++;
        sinceHs = 0;
      end else begin
        sinceHs++;
      end
      if (if_valid_o && rRedir) expKill++;
      if (rRedir) expPc = rRpc & ~32'h3;

      if (respNow) begin
        if (killPending || rRedir) expKill++;
        outstanding = 1'b0;
      end else if (outstanding) begin
        if (rRedir) killPending = 1'b1;
        lat--;
      end

      if (imem_req_o && rGnt) begin
        checkOutput("single_outstanding", {127'd0, outstanding}, 128'd0);
        checkOutput("addr_aligned", {126'd0, imem_addr_o[1:0]}, 128'd0);
        outstanding = 1'b1;
        killPending = rRedir;
        respAddr    = imem_addr_o;
        lat         = $urandom_range(0, 2);
      end

      if (sinceHs > 200) begin
        nTests++;
        nFail++;
        $display("[TB] FAIL watchdog: %0d cycles without a delivery, required at most 200", sinceHs);
        break;
      end
    end
    @(negedge clk);
    checkOutput("liveness", {127'd0, (nDeliv >= 150)}, 128'd1);
`ifdef IFETCH_PERF_EN
    checkOutput("perf_fetch_rand", {96'd0, perf_fetch_cnt_o}, {96'd0, expFetch});
    checkOutput("perf_kill_rand",  {96'd0, perf_kill_cnt_o},  {96'd0, expKill});
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch stage, directly upstream of the IF/ID register, which feeds instruction decode.
- Holds the architectural fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Presents {pc, instr} to IF/ID with a valid/ready handshake.
- Handles execute-stage redirects (branch/jump), including discarding an in-flight response for a stale PC.

Parameters:
- PC_W, 32, PC width (matches `PC_WIDTH).
- INSTR_W, 32, instruction width (matches `INSTR_WIDTH).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- redirect_i  in  1  redirect request from EX; one-cycle pulse.
- redirect_pc_i  in  PC_W  redirect target; bits [1:0] ignored and treated as 0.
- imem_req_o  out  1  instruction memory request.
- imem_addr_o  out  PC_W  request address, word aligned.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid.
- imem_rdata_i  in  INSTR_W  response instruction.
- if_valid_o  out  1  {if_pc_o, if_instr_o} valid toward IF/ID.
- if_ready_i  in  1  IF/ID accepts this cycle.
- if_pc_o  out  PC_W  PC of presented instruction.
- if_instr_o  out  INSTR_W  presented instruction.

Behaviour:
- Single clock; all state updates on the rising edge of clk.
- rst has priority over every other input. Reset values: state=BOOT, pc_q=RESET_PC, kill_q=0, imem_req_o=0, if_valid_o=0, if_pc_o=0, if_instr_o=0.
- At most one request is outstanding.
- Output buffer holds one instruction. if_pc_o and if_instr_o are registered and change only on a buffer load.
- imem_addr_o = pc_q in every cycle.
- States:
  - BOOT: req=0. Next cycle -> REQ. Ignores any rvalid left over from before reset.
  - REQ: req=1, addr=pc_q.
    - On gnt: req_pc_q<=pc_q, pc_q<=pc_q+4 (wraps modulo 2^PC_W), -> WAIT.
    - Without gnt: stay in REQ; addr stays stable unless a redirect occurs.
  - WAIT: req=0.
    - On rvalid with kill_q=1: drop the data, kill_q<=0, -> REQ.
    - On rvalid with kill_q=0: if_pc_o<=req_pc_q, if_instr_o<=imem_rdata_i, if_valid_o<=1, -> HOLD.
  - HOLD: if_valid_o=1, req=0. On if_ready_i: if_valid_o<=0, -> REQ.
- Throughput is one instruction per three cycles with zero-wait memory (REQ, WAIT, HOLD). This is acceptable for the in-order core.
- Redirect (redirect_i=1), in any state other than BOOT:
  - pc_q <= {redirect_pc_i[PC_W-1:2], 2'b00}.
  - Redirect takes priority over the +4 update and over if_ready_i.
  - REQ without gnt: next state REQ; the next cycle requests the new PC.
  - REQ with gnt in the same cycle: the granted request was for the old PC. -> WAIT with kill_q<=1.
  - WAIT without rvalid: kill_q<=1, stay in WAIT.
  - WAIT with rvalid in the same cycle: drop the data, -> REQ.
  - HOLD: if_valid_o<=0, the buffer is discarded, -> REQ. The instruction is not delivered even if if_ready_i=1 that cycle.
  - Instruction following a redirect is presented with if_pc_o = the redirect target.
- Protocol violations: rvalid in REQ, HOLD or BOOT is ignored. gnt outside REQ is ignored.
- if_valid_o stays high until accepted or until a redirect.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetch_cnt_o (32) and perf_kill_cnt_o (32). Both reset to 0 and wrap at 2^32.
  - fetch_cnt increments on each IF/ID handshake (if_valid_o & if_ready_i & !redirect_i).
  - kill_cnt increments on each dropped response and on each HOLD discard caused by a redirect.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, memory grants immediately and returns rdata one cycle later, if_ready_i=1 -> req at cycle 1 with addr 0x0, then 0x4, 0x8. IF/ID receives pcs 0x0, 0x4, 0x8 in order, one per 3 cycles.
- gnt withheld 4 cycles at addr 0x10 -> imem_req_o held 1 and addr held 0x10 throughout; one fetch occurs once gnt is asserted.
- if_ready_i=0 for 5 cycles in HOLD with pc 0x8 -> if_valid_o, if_pc_o=0x8 and if_instr_o stable; no new request; delivered on the ready cycle.
- Redirect to 0x100 while in WAIT for 0x4 -> response for 0x4 dropped, next request addr 0x100, if_pc_o=0x100 delivered; 0x4 never valid.
- Redirect to 0x203 in the same cycle as gnt for 0xC -> 0xC response dropped, next addr 0x200 (low bits cleared).
- Redirect to 0x40 in HOLD with if_ready_i=1 -> no handshake that cycle, if_valid_o=0 next cycle, next addr 0x40. With IFETCH_PERF_EN, kill_cnt increments by 1.
